// File: rtl/coram_pkg.sv
// Shared constants and helpers for the CoRAM channel FIFO and its RAM.
package coram_pkg;

   localparam int CORAM_DEFAULT_ADDR_LEN   = 4;
   localparam int CORAM_DEFAULT_DATA_WIDTH = 32;

   function automatic int unsigned coram_depth(input int unsigned addr_len);
      return 32'd1 << addr_len;
   endfunction

endpackage

// File: rtl/coram_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with a resettable output register.
module coram_fifo_ram
   import coram_pkg::*;
#(
   parameter int ADDR_LEN   = CORAM_DEFAULT_ADDR_LEN,
   parameter int DATA_WIDTH = CORAM_DEFAULT_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  we_i,
   input  logic [ADDR_LEN-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_LEN-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned DEPTH = coram_depth(ADDR_LEN);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Array write port; contents deliberately survive reset
   always_ff @(posedge CLK) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register holds its value until the next read
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/coram_channel.sv
// CoRAM channel core: single-clock FIFO with ENQ/DEQ handshakes and
// full/empty plus almost-full/almost-empty flags decoded from the count.
module coram_channel
   import coram_pkg::*;
#(
   parameter     CORAM_THREAD_NAME = "undefined",
   parameter int CORAM_ID          = 0,
   parameter int CORAM_ADDR_LEN    = CORAM_DEFAULT_ADDR_LEN,
   parameter int CORAM_DATA_WIDTH  = CORAM_DEFAULT_DATA_WIDTH
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [CORAM_DATA_WIDTH-1:0] D,
   input  logic                        ENQ,
   output logic                        FULL,
   output logic                        ALM_FULL,
   output logic [CORAM_DATA_WIDTH-1:0] Q,
   input  logic                        DEQ,
   output logic                        EMPTY,
   output logic                        ALM_EMPTY
);

   localparam int AW = CORAM_ADDR_LEN;
   localparam int unsigned DEPTH        = coram_depth(AW);
   localparam int unsigned ALM_FULL_LVL = DEPTH - 32'd2;
   localparam logic [AW:0] DEPTH_C      = DEPTH[AW:0];
   localparam logic [AW:0] ALM_FULL_C   = ALM_FULL_LVL[AW:0];

   // Thread name and ID only tag the instance for the control-thread compiler
   if (CORAM_ID < 0 || $bits(CORAM_THREAD_NAME) == 0) begin : g_tag_unusual
   end

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          enq_ok_s, deq_ok_s;

   assign FULL      = (count_q == DEPTH_C);
   assign ALM_FULL  = (count_q >= ALM_FULL_C);
   assign EMPTY     = (count_q == {(AW+1){1'b0}});
   assign ALM_EMPTY = (count_q <= {{AW{1'b0}}, 1'b1});

   // Accept decisions use the flags as they stand at the start of the cycle
   always_comb begin
      enq_ok_s = ENQ & ~FULL;
      deq_ok_s = DEQ & ~EMPTY;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      if (enq_ok_s) begin
         wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         wptr_d = wptr_q;
      end
      if (deq_ok_s) begin
         rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         rptr_d = rptr_q;
      end
      case ({enq_ok_s, deq_ok_s})
         2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   coram_fifo_ram #(
      .ADDR_LEN   (AW),
      .DATA_WIDTH (CORAM_DATA_WIDTH)
   ) u_ram (
      .CLK     (CLK),
      .RST     (RST),
      .we_i    (enq_ok_s),
      .waddr_i (wptr_q),
      .wdata_i (D),
      .re_i    (deq_ok_s),
      .raddr_i (rptr_q),
      .rdata_o (Q)
   );

endmodule

// File: tb/tb_coram_channel.sv
// Randomized and directed bench for coram_channel (DEPTH=4, W=32) against a queue model.
module tb_coram_channel;

   localparam int AL    = 2;
   localparam int W     = 32;
   localparam int DEPTH = 4;

   logic         CLK;
   logic         RST;
   logic [W-1:0] D;
   logic         ENQ;
   logic         DEQ;
   logic         FULL, ALM_FULL, EMPTY, ALM_EMPTY;
   logic [W-1:0] Q;

   int           checks;
   int           errors;
   logic [W-1:0] model_q[$];
   logic [W-1:0] q_exp;

   coram_channel #(
      .CORAM_THREAD_NAME ("tb_thread"),
      .CORAM_ID          (3),
      .CORAM_ADDR_LEN    (AL),
      .CORAM_DATA_WIDTH  (W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .D         (D),
      .ENQ       (ENQ),
      .FULL      (FULL),
      .ALM_FULL  (ALM_FULL),
      .Q         (Q),
      .DEQ       (DEQ),
      .EMPTY     (EMPTY),
      .ALM_EMPTY (ALM_EMPTY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = model_q.size();
      check_eq({tag, ".Q"},         Q,                         q_exp);
      check_eq({tag, ".EMPTY"},     {31'd0, EMPTY},            {31'd0, n == 0});
      check_eq({tag, ".ALM_EMPTY"}, {31'd0, ALM_EMPTY},        {31'd0, n <= 1});
      check_eq({tag, ".FULL"},      {31'd0, FULL},             {31'd0, n == DEPTH});
      check_eq({tag, ".ALM_FULL"},  {31'd0, ALM_FULL},         {31'd0, n >= DEPTH - 2});
   endtask

   // One clock cycle: drive, let the edge happen, update the model, check
   task automatic cyc(input logic e, input logic d, input logic [W-1:0] data, input string tag);
      bit do_enq, do_deq;
      ENQ = e;
      DEQ = d;
      D   = data;
      do_enq = e && (model_q.size() < DEPTH);
      do_deq = d && (model_q.size() > 0);
      @(posedge CLK);
      if (do_deq) q_exp = model_q.pop_front();
      if (do_enq) model_q.push_back(data);
      #1;
      ENQ = 1'b0;
      DEQ = 1'b0;
      check_all(tag);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      q_exp  = '0;
      ENQ = 1'b0; DEQ = 1'b0; D = '0;
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_all("reset");
      @(negedge CLK);
      RST = 1'b1;
      cyc(1'b0, 1'b0, 32'h0, "idle");

      // Fill, then overflow attempt
      cyc(1'b1, 1'b0, 32'h11, "enq1");
      check_eq("almE_still1", {31'd0, ALM_EMPTY}, 32'd1);
      cyc(1'b1, 1'b0, 32'h22, "enq2");
      check_eq("almF_at2", {31'd0, ALM_FULL}, 32'd1);
      check_eq("almE_fall2", {31'd0, ALM_EMPTY}, 32'd0);
      cyc(1'b1, 1'b0, 32'h33, "enq3");
      check_eq("full_not3", {31'd0, FULL}, 32'd0);
      cyc(1'b1, 1'b0, 32'h44, "enq4");
      check_eq("full_at4", {31'd0, FULL}, 32'd1);
      cyc(1'b1, 1'b0, 32'h55, "enq_drop");

      // Drain in order, then dequeue from empty
      cyc(1'b0, 1'b1, 32'h0, "deq1");
      check_eq("deq1_val", Q, 32'h11);
      cyc(1'b0, 1'b1, 32'h0, "deq2");
      cyc(1'b0, 1'b1, 32'h0, "deq3");
      cyc(1'b0, 1'b1, 32'h0, "deq4");
      check_eq("deq4_val", Q, 32'h44);
      check_eq("empty_after", {31'd0, EMPTY}, 32'd1);
      cyc(1'b0, 1'b1, 32'h0, "deq_drop");
      check_eq("q_hold", Q, 32'h44);

      // Empty: ENQ+DEQ enqueues only, Q unchanged
      cyc(1'b1, 1'b1, 32'h66, "both_empty");
      check_eq("both_empty_q", Q, 32'h44);
      cyc(1'b1, 1'b0, 32'h77, "pre2");
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 32'h100 + i, "both_cnt2");
      cyc(1'b1, 1'b0, 32'h200, "pre3");
      cyc(1'b1, 1'b0, 32'h201, "pre4");
      check_eq("full_pre", {31'd0, FULL}, 32'd1);
      cyc(1'b1, 1'b1, 32'h99, "both_full");
      check_eq("both_full_ok", {31'd0, FULL}, 32'd0);

      // Drain, then wrap-around pairs
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h0, "drain");
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0, 32'h300 + i, "wrap_enq");
         cyc(1'b0, 1'b1, 32'h0, "wrap_deq");
         check_eq("wrap_val", Q, 32'h300 + i);
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "rand");
      end

      // Asynchronous reset mid-stream with three entries
      while (model_q.size() > 0) cyc(1'b0, 1'b1, 32'h0, "pre_rst_drain");
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h400 + i, "pre_rst_fill");
      #2;
      RST = 1'b0;
      #1;
      model_q.delete();
      q_exp = '0;
      check_all("async_rst");
      @(negedge CLK);
      RST = 1'b1;
      cyc(1'b1, 1'b0, 32'hAB, "post_enq");
      cyc(1'b0, 1'b1, 32'h0, "post_deq");
      check_eq("post_val", Q, 32'hAB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
